// File: rtl/pilot_remove.sv
// Receive-side pilot stripper: drops framed pilot words from a 32-bit stream,
// exports them on a side port, checks them against the expected word and counts mismatches.
module pilot_remove #(
    parameter int CNT_W = 13,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] frame_length,
    input  logic [CNT_W-1:0] pilot_interval,
    input  logic [31:0]      pilot_value,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             frame_end,
    output logic [31:0]      pilot_out,
    output logic             pilot_valid,
    output logic             pilot_error,
    output logic [ERR_W-1:0] err_count,
    output logic             cfg_error
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fl_q, fl_d, pi_q, pi_d, pos_q, pos_d, sub_q, sub_d;
    logic [31:0]      pv_q, pv_d, m_data_q, m_data_d, pilot_out_q, pilot_out_d;
    logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic             frame_end_q, frame_end_d, pilot_valid_q, pilot_valid_d;
    logic             pilot_error_q, pilot_error_d, cfg_error_q, cfg_error_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             accept_s, relatch_s, cfg_bad_s, last_pos_s, is_pilot_s;
    logic [CNT_W-1:0] eff_fl_s, eff_pi_s;
    logic [31:0]      eff_pv_s;

    assign s_ready  = rst & (~m_valid_q | m_ready);
    assign accept_s = s_valid & s_ready;

    // Effective configuration: fresh inputs at frame start, shadow copy mid-frame.
    // An invalid pair pins pos at 0, so it is relatched on every accept.
    always_comb begin
        relatch_s  = (state_q == IDLE) || (pos_q == CNT_ZERO);
        eff_fl_s   = relatch_s ? frame_length   : fl_q;
        eff_pi_s   = relatch_s ? pilot_interval : pi_q;
        eff_pv_s   = relatch_s ? pilot_value    : pv_q;
        cfg_bad_s  = (eff_fl_s == CNT_ZERO) || (eff_pi_s == CNT_ZERO);
        last_pos_s = (pos_q == (eff_fl_s - CNT_ONE));
        is_pilot_s = ~cfg_bad_s && (sub_q == CNT_ZERO);
    end

    // Next-state for FSM, counters, data/pilot outputs and monitors.
    always_comb begin
        state_d       = state_q;
        fl_d          = fl_q;
        pi_d          = pi_q;
        pv_d          = pv_q;
        pos_d         = pos_q;
        sub_d         = sub_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        pilot_out_d   = pilot_out_q;
        cfg_error_d   = cfg_error_q;
        err_count_d   = err_count_q;
        frame_end_d   = 1'b0;
        pilot_valid_d = 1'b0;
        pilot_error_d = 1'b0;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        if (accept_s) begin
            state_d = RUN;
            fl_d    = eff_fl_s;
            pi_d    = eff_pi_s;
            pv_d    = eff_pv_s;
            if (cfg_bad_s) begin
                cfg_error_d = 1'b1;
                m_valid_d   = 1'b1;
                m_data_d    = s_data;
                m_last_d    = 1'b0;
                pos_d       = CNT_ZERO;
                sub_d       = CNT_ZERO;
            end else begin
                if (is_pilot_s) begin
                    pilot_out_d   = s_data;
                    pilot_valid_d = 1'b1;
                    if (s_data != eff_pv_s) begin
                        pilot_error_d = 1'b1;
                        err_count_d   = (err_count_q == ERR_MAX) ? ERR_MAX : (err_count_q + ERR_ONE);
                    end else begin
                        pilot_error_d = 1'b0;
                    end
                end else begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                    m_last_d  = last_pos_s;
                end
                if (last_pos_s) begin
                    frame_end_d = 1'b1;
                    pos_d       = CNT_ZERO;
                    sub_d       = CNT_ZERO;
                end else begin
                    pos_d = pos_q + CNT_ONE;
                    sub_d = (sub_q == (eff_pi_s - CNT_ONE)) ? CNT_ZERO : (sub_q + CNT_ONE);
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            fl_q          <= CNT_ZERO;
            pi_q          <= CNT_ZERO;
            pv_q          <= 32'h0000_0000;
            pos_q         <= CNT_ZERO;
            sub_q         <= CNT_ZERO;
            m_data_q      <= 32'h0000_0000;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            pilot_out_q   <= 32'h0000_0000;
            cfg_error_q   <= 1'b0;
            err_count_q   <= {ERR_W{1'b0}};
            frame_end_q   <= 1'b0;
            pilot_valid_q <= 1'b0;
            pilot_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fl_q          <= fl_d;
            pi_q          <= pi_d;
            pv_q          <= pv_d;
            pos_q         <= pos_d;
            sub_q         <= sub_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_last_q      <= m_last_d;
            pilot_out_q   <= pilot_out_d;
            cfg_error_q   <= cfg_error_d;
            err_count_q   <= err_count_d;
            frame_end_q   <= frame_end_d;
            pilot_valid_q <= pilot_valid_d;
            pilot_error_q <= pilot_error_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign frame_end   = frame_end_q;
    assign pilot_out   = pilot_out_q;
    assign pilot_valid = pilot_valid_q;
    assign pilot_error = pilot_error_q;
    assign err_count   = err_count_q;
    assign cfg_error   = cfg_error_q;

endmodule
